// File: rtl/alu_exec_if.sv
// alu_exec_if: controller-to-execute-stage operand, op code and handshake bundle
interface alu_exec_if #(parameter int WIDTH = 32, parameter int SHW = 5);
  logic             start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             zero;
  logic             busy;
  logic             done;
  modport master (output start, ALUControl, A, B, shamt, input result, hi, lo, zero, busy, done);
  modport slave (input start, ALUControl, A, B, shamt, output result, hi, lo, zero, busy, done);
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU execute stage with iterative signed shift-add multiplier
module alu_exec_unit #(parameter int WIDTH = 32, parameter int SHW = 5) (
  input logic clk,
  input logic rst,
  alu_exec_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] alu_res, mcand, mplr, abs_a, abs_b;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH:0] sum;
  logic [SHW-1:0] cnt;
  logic sign, go, is_mult;
  assign is_mult = bus.ALUControl == 4'b1100;
  assign go = bus.start && state == IDLE;
  assign bus.busy = state != IDLE;
  assign abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign abs_b = bus.B[WIDTH-1] ? -bus.B : bus.B;
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mplr[0] ? mcand : {WIDTH{1'b0}}};
  assign prod = sign ? -acc : acc;
  always_comb begin
    alu_res = '0;
    case (bus.ALUControl)
      4'b0000: alu_res = bus.A & bus.B;
      4'b0001: alu_res = bus.A | bus.B;
      4'b0010: alu_res = bus.A ^ bus.B;
      4'b0011: alu_res = ~(bus.A | bus.B);
      4'b0100: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      4'b0101: alu_res = bus.B << bus.shamt;
      4'b0110: alu_res = bus.B >> bus.shamt;
      4'b0111: alu_res = bus.A + bus.B;
      4'b1000: alu_res = bus.A - bus.B;
      4'b1011: alu_res = $signed(bus.B) >>> bus.shamt;
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = go && is_mult ? MUL : IDLE;
    else if (state == MUL) state_n = cnt == SHW'(WIDTH-1) ? FIX : MUL;
    else state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.result <= '0;
      bus.hi <= '0;
      bus.lo <= '0;
      bus.zero <= 1'b1;
      bus.done <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplr <= '0;
      cnt <= '0;
      sign <= 1'b0;
    end else begin
      state <= state_n;
      bus.done <= 1'b0;
      if (go && !is_mult) begin
        bus.result <= alu_res;
        bus.zero <= alu_res == '0;
        bus.done <= 1'b1;
      end
      if (go && is_mult) begin
        mcand <= abs_a;
        mplr <= abs_b;
        sign <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
        acc <= '0;
        cnt <= '0;
      end
      // add-then-shift keeps the carry out of the upper half in the shifted-in bit
      if (state == MUL) begin
        acc <= {sum, acc[WIDTH-1:1]};
        mplr <= mplr >> 1;
        cnt <= cnt + SHW'(1);
      end
      if (state == FIX) begin
        {bus.hi, bus.lo} <= prod;
        bus.result <= prod[WIDTH-1:0];
        bus.zero <= prod == '0;
        bus.done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed expectations for alu_exec_unit
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int done_cyc, busy_cnt, n_done;
  alu_exec_if #(.WIDTH(32), .SHW(5)) bus();
  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    bus.start = 1'b1;
    bus.ALUControl = c;
    bus.A = a;
    bus.B = b;
    bus.shamt = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ALUControl = 4'($urandom);
    bus.A = $urandom;
    bus.B = $urandom;
    bus.shamt = 5'($urandom);
  endtask
  task automatic single(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [31:0] exp);
    op(c, a, b, s);
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_res"}, 64'(bus.result), 64'(exp));
    chk({tag, "_zero"}, 64'(bus.zero), 64'(exp == 32'd0));
  endtask
  task automatic run_mult(input int inject_at, output int dcyc, output int bcnt, output int nd);
    dcyc = 0;
    bcnt = 0;
    nd = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == inject_at) begin
        bus.start = 1'b1;
        bus.ALUControl = 4'b0111;
        bus.A = 32'd1;
        bus.B = 32'd1;
      end else bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        nd++;
        if (dcyc == 0) dcyc = k;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.ALUControl = 4'b0000;
    bus.A = '0;
    bus.B = '0;
    bus.shamt = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    single("add_ovf", 4'b0111, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000);
    @(negedge clk);
    chk("add_done_low", 64'(bus.done), 64'd0);
    chk("add_hold", 64'(bus.result), 64'h80000000);
    chk("add_hilo_untouched", {bus.hi, bus.lo}, 64'd0);
    single("sub_zero", 4'b1000, 32'd5, 32'd5, 5'd0, 32'd0);
    single("slt_neg", 4'b0100, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1);
    single("slt_pos", 4'b0100, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0);
    single("undef", 4'b1111, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'd0);
    single("sra", 4'b1011, 32'h0, 32'h80000000, 5'd4, 32'hF8000000);
    single("srl", 4'b0110, 32'h0, 32'h80000000, 5'd4, 32'h08000000);
    single("sll", 4'b0101, 32'h0, 32'h1, 5'd31, 32'h80000000);
    single("and", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000);
    single("or", 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0);
    single("xor", 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0);
    single("nor", 4'b0011, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF);
    single("sub_wrap", 4'b1000, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    op(4'b1100, 32'hFFFFFFFD, 32'd7, 5'd0);
    run_mult(0, done_cyc, busy_cnt, n_done);
    chk("m1_done_cyc", 64'(done_cyc), 64'd34);
    chk("m1_busy_cycles", 64'(busy_cnt), 64'd33);
    chk("m1_n_done", 64'(n_done), 64'd1);
    chk("m1_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
    chk("m1_result", 64'(bus.result), 64'hFFFFFFEB);
    chk("m1_zero", 64'(bus.zero), 64'd0);
    op(4'b1100, 32'h80000000, 32'h80000000, 5'd0);
    run_mult(5, done_cyc, busy_cnt, n_done);
    chk("m2_done_cyc", 64'(done_cyc), 64'd34);
    chk("m2_n_done", 64'(n_done), 64'd1);
    chk("m2_hilo", {bus.hi, bus.lo}, 64'h40000000_00000000);
    chk("m2_result", 64'(bus.result), 64'd0);
    chk("m2_zero", 64'(bus.zero), 64'd0);
    op(4'b1100, 32'hFFFFFFFF, 32'd5, 5'd0);
    run_mult(0, done_cyc, busy_cnt, n_done);
    chk("m3_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFB);
    op(4'b1100, 32'd3, 32'd5, 5'd0);
    repeat (9) @(negedge clk);
    chk("rm_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_busy", 64'(bus.busy), 64'd0);
    chk("rm_done", 64'(bus.done), 64'd0);
    chk("rm_result", 64'(bus.result), 64'd0);
    chk("rm_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rm_zero", 64'(bus.zero), 64'd1);
    run_mult(0, done_cyc, busy_cnt, n_done);
    chk("rm_no_done", 64'(n_done), 64'd0);
    single("add_after_rst", 4'b0111, 32'd2, 32'd3, 5'd0, 32'd5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
